// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side frame controller.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_HOLD    = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_CHK  = 2'd3;

  localparam logic [7:0] HEADER_DEF = 8'h55;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: 8-bit x 2**ADDR_W register file, synchronous write, asynchronous read.
module uart_frame_buf #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem_q [2**ADDR_W];

  // Payload contents carry no reset; only bytes below frame_len are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser: header, cmd, len, payload[len], checksum; validated frames are
// held for the consumer until acknowledged.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] HEADER  = HEADER_DEF,
  parameter int         MAX_LEN = 16,
  parameter int         ADDR_W  = 4,
  parameter int         TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              frame_valid,
  output logic [7:0]        frame_cmd,
  output logic [7:0]        frame_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              frame_ack,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              overrun
);

  localparam int               TMO_W     = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  state_e           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d, len_q, len_d, sum_q, sum_d, cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             frame_valid_q, frame_valid_d;
  logic [7:0]       frame_cmd_q, frame_cmd_d, frame_len_q, frame_len_d;
  logic             err_q, err_d, overrun_q, overrun_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             active_s, tmo_hit_s, wr_en_s;

  // Inter-byte gap watchdog; a byte landing in the expiry cycle takes priority.
  always_comb begin
    active_s  = state_q inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHK};
    tmo_hit_s = 1'b0;
    tmo_d     = '0;
    if (active_s && !rx_valid) begin
      if (tmo_q == TMO_LAST) begin
        tmo_hit_s = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Next-state, checksum and output decode.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    len_d         = len_q;
    sum_d         = sum_q;
    cnt_d         = cnt_q;
    frame_valid_d = frame_valid_q;
    frame_cmd_d   = frame_cmd_q;
    frame_len_d   = frame_len_q;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    overrun_d     = 1'b0;
    wr_en_s       = 1'b0;

    if (tmo_hit_s) begin
      err_d      = 1'b1;
      err_code_d = ERR_TMO;
      state_d    = ST_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == HEADER) begin
            state_d = ST_CMD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD: begin
          cmd_d   = rx_data;
          sum_d   = rx_data;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          if (rx_data > MAX_LEN_B) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_d   = rx_data;
            sum_d   = sum_q + rx_data;
            cnt_d   = 8'd0;
            state_d = (rx_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          wr_en_s = 1'b1;
          sum_d   = sum_q + rx_data;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_CHK: begin
          if (rx_data == sum_q) begin
            frame_valid_d = 1'b1;
            frame_cmd_d   = cmd_q;
            frame_len_d   = len_q;
            state_d       = ST_HOLD;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = ST_IDLE;
          end
        end
        ST_HOLD: begin
          // With a simultaneous ack the byte is judged as if already idle.
          if (frame_ack) begin
            frame_valid_d = 1'b0;
            state_d       = (rx_data == HEADER) ? ST_CMD : ST_IDLE;
          end else begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_HOLD && frame_ack) begin
      frame_valid_d = 1'b0;
      state_d       = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cmd_q         <= 8'd0;
      len_q         <= 8'd0;
      sum_q         <= 8'd0;
      cnt_q         <= 8'd0;
      tmo_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_cmd_q   <= 8'd0;
      frame_len_q   <= 8'd0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      len_q         <= len_d;
      sum_q         <= sum_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      frame_valid_q <= frame_valid_d;
      frame_cmd_q   <= frame_cmd_d;
      frame_len_q   <= frame_len_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      overrun_q     <= overrun_d;
    end
  end

  uart_frame_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (cnt_q[ADDR_W-1:0]),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign frame_valid = frame_valid_q;
  assign frame_cmd   = frame_cmd_q;
  assign frame_len   = frame_len_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: frame-level reference model, decoupled monitor.
module tb_uart_frame_ctrl;

  localparam int T       = 100;
  localparam int MAX_LEN = 16;
  localparam logic [1:0] K_FRM = 2'd0;
  localparam logic [1:0] K_ERR = 2'd1;
  localparam logic [1:0] K_OVR = 2'd2;

  typedef struct packed {
    logic [1:0]       kind;
    logic [1:0]       code;
    logic [7:0]       cmd;
    logic [7:0]       len;
    logic [15:0][7:0] pl;
    int               cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       frame_ack = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic       frame_valid, err, overrun;
  logic [7:0] frame_cmd, frame_len, rd_data;
  logic [1:0] err_code;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   gap_max = 3;
  exp_t sb[$];
  exp_t held = '0;
  logic fv_prev = 1'b0;

  uart_frame_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_len(frame_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_ack(frame_ack),
    .err(err), .err_code(err_code), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: outcome of one frame from its fields, by the frame rules alone.
  function automatic exp_t model(input logic [7:0] cmd, input int len,
                                 input logic [15:0][7:0] pl, input logic [7:0] c);
    exp_t e;
    int   s;
    e = '0;
    e.cmd = cmd;
    e.len = 8'(len);
    e.pl  = pl;
    if (len > MAX_LEN) begin
      e.kind = K_ERR;
      e.code = 2'd1;
    end else begin
      s = cmd + len;
      for (int i = 0; i < len; i++) s += pl[i];
      if (c == 8'(s % 256)) e.kind = K_FRM;
      else begin
        e.kind = K_ERR;
        e.code = 2'd3;
      end
    end
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gap();
    idle($urandom_range(0, gap_max));
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int len, input logic [15:0][7:0] pl,
                           input logic [7:0] c, input bit skip_hdr, output logic [1:0] kind);
    exp_t e;
    e = model(cmd, len, pl, c);
    kind = e.kind;
    if (!skip_hdr) begin
      gap();
      send_byte(8'h55);
    end
    gap();
    send_byte(cmd);
    gap();
    if (len > MAX_LEN) begin
      e.cyc = cyc + 1;
      sb.push_back(e);
      send_byte(8'(len));
    end else begin
      send_byte(8'(len));
      for (int i = 0; i < len; i++) begin
        gap();
        send_byte(pl[i]);
      end
      gap();
      e.cyc = cyc + 1;
      sb.push_back(e);
      send_byte(c);
    end
  endtask

  // mode 0: plain ack; 1: stray byte first (overrun); 2: ack together with a header.
  task automatic hold_ack(input int mode, input int len);
    exp_t e;
    idle(len + 3);
    if (mode == 1) begin
      e = '0;
      e.kind = K_OVR;
      e.cyc = cyc + 1;
      sb.push_back(e);
      send_byte(8'($urandom));
      idle(2);
    end
    frame_ack = 1'b1;
    if (mode == 2) begin
      rx_valid = 1'b1;
      rx_data  = 8'h55;
    end
    @(negedge clk);
    frame_ack = 1'b0;
    rx_valid  = 1'b0;
    chk("valid_after_ack", 32'(frame_valid), 32'd0);
  endtask

  task automatic take(input logic [1:0] kind);
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_event", 32'(kind), 32'hFFFF);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_cycle", 32'(cyc), 32'(e.cyc));
      if (kind == e.kind && kind == K_FRM) begin
        held = e;
        chk("frame_cmd", 32'(frame_cmd), 32'(e.cmd));
        chk("frame_len", 32'(frame_len), 32'(e.len));
      end else if (kind == e.kind && kind == K_ERR) begin
        chk("err_code", 32'(err_code), 32'(e.code));
      end
    end
  endtask

  // Monitor: pops the scoreboard on every DUT event and audits the held frame.
  initial begin
    int nxt;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fv_prev = 1'b0;
      end else begin
        if (frame_valid && !fv_prev) take(K_FRM);
        if (err) take(K_ERR);
        if (overrun) take(K_OVR);
        if (frame_valid) begin
          chk("hold_cmd", 32'(frame_cmd), 32'(held.cmd));
          chk("hold_len", 32'(frame_len), 32'(held.len));
          if (held.len != 8'd0) begin
            if (8'(rd_addr) < held.len) chk("rd_data", 32'(rd_data), 32'(held.pl[rd_addr]));
            nxt = int'(rd_addr) + 1;
            rd_addr = (nxt >= int'(held.len)) ? 4'd0 : 4'(nxt);
          end
        end
        fv_prev = frame_valid;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0][7:0] pl;
    logic [1:0]       kind;
    logic [7:0]       cmd, c;
    int               len, s, mode, sc;
    bit               skip;

    repeat (3) @(negedge clk);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_frame_cmd", 32'(frame_cmd), 32'd0);
    chk("rst_frame_len", 32'(frame_len), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Good frame A1 / 10 20 30 / checksum 04.
    pl = '0;
    pl[0] = 8'h10; pl[1] = 8'h20; pl[2] = 8'h30;
    run_frame(8'hA1, 3, pl, 8'h04, 1'b0, kind);
    hold_ack(0, 3);

    // Noise then zero-length frame.
    send_byte(8'h00);
    send_byte(8'hFF);
    pl = '0;
    run_frame(8'h07, 0, pl, 8'h07, 1'b0, kind);
    hold_ack(0, 0);

    // Bad checksum, then a good frame.
    pl[0] = 8'h22;
    run_frame(8'hA1, 1, pl, 8'h00, 1'b0, kind);
    run_frame(8'hA1, 1, pl, 8'hC4, 1'b0, kind);
    hold_ack(1, 1);

    // Bad length; trailing bytes ignored.
    run_frame(8'h01, 17, pl, 8'h00, 1'b0, kind);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    idle(4);

    // Timeout after cmd byte.
    begin
      exp_t e;
      send_byte(8'h55);
      e = '0;
      e.kind = K_ERR;
      e.code = 2'd2;
      e.cyc  = cyc + 1 + T;
      sb.push_back(e);
      send_byte(8'hA1);
      idle(T + 3);
    end

    // Byte lands exactly in the expiry cycle: accepted, no timeout.
    begin
      exp_t e;
      send_byte(8'h55);
      send_byte(8'hA1);
      idle(T - 1);
      send_byte(8'h00);
      pl = '0;
      e = model(8'hA1, 0, pl, 8'hA1);
      e.cyc = cyc + 1;
      sb.push_back(e);
      send_byte(8'hA1);
      hold_ack(2, 0);
      pl[0] = 8'h5A; pl[1] = 8'h01;
      run_frame(8'h3C, 2, pl, 8'h99, 1'b1, kind);
      hold_ack(0, 2);
    end

    // Reset mid-payload.
    send_byte(8'h55);
    send_byte(8'h10);
    send_byte(8'h04);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("mid_rst_frame_cmd", 32'(frame_cmd), 32'd0);
    chk("mid_rst_frame_len", 32'(frame_len), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_err_code", 32'(err_code), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Randomized traffic.
    skip = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if (!skip) begin
        for (int n = $urandom_range(0, 2); n > 0; n--) begin
          c = 8'($urandom);
          if (c == 8'h55) c = 8'h56;
          gap();
          send_byte(c);
        end
      end
      sc  = $urandom_range(0, 5);
      len = (sc == 0) ? $urandom_range(17, 20) : $urandom_range(0, 16);
      cmd = 8'($urandom);
      pl  = {$urandom, $urandom, $urandom, $urandom};
      s = cmd + len;
      for (int i = 0; i < len && i < 16; i++) s += pl[i];
      c = 8'(s % 256);
      if (sc == 1) c = c ^ 8'($urandom_range(1, 255));
      run_frame(cmd, len, pl, c, skip, kind);
      skip = 1'b0;
      if (kind == K_FRM) begin
        mode = $urandom_range(0, 2);
        if (it == 39 && mode == 2) mode = 0;
        hold_ack(mode, len);
        skip = (mode == 2);
      end
    end

    idle(20);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
